// File: rtl/mem_pkg.sv
// Shared types and sizing for the SRAM write path: scheduler states,
// completion error codes and the legal command length.
package mem_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int ACCUM_SIZE     = 4096;
  localparam int SYS_COL        = 16;
  localparam int ACCUM_ROW      = ACCUM_SIZE / SYS_COL;
  localparam int MAX_ROW_DEF    = ACCUM_ROW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } wr_sched_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } cmp_err_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_wr_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int ID_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    if (en) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = (int'(ptr) + off) % NUM_REQ;
        if (!gnt_valid && req[idx]) begin
          grant[idx] = 1'b1;
          gnt_id     = ID_W'(idx);
          gnt_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_wr_sched.sv
// Round-robin scheduler sharing one SRAM write controller between the DMA
// and drain engines; one command in flight, completion reported per command.
//
//   state | meaning
//   IDLE  | pick a requester, raise its ready, accept and length-check
//   ISSUE | one-cycle wr_en_in pulse with the captured command
//   WAIT  | hold command, wait for wr_done rising edge or timeout
//   DONE  | one-cycle cmp_valid with id and error code
module mem_wr_sched
  import mem_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int MAX_ROW    = MAX_ROW_DEF,
  parameter int TIMEOUT    = 1024,
  localparam int ID_W      = id_width(NUM_REQ),
  localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_num_row,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_base_addr,
  output logic                                 wr_en_in,
  output logic [DATA_WIDTH-1:0]                num_row,
  output logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic                                 wr_done,
  output logic                                 busy,
  output logic                                 cmp_valid,
  output logic [ID_W-1:0]                      cmp_id,
  output logic [1:0]                           cmp_err
);

  wr_sched_state_e state, state_d;
  logic [ID_W-1:0]       ptr, ptr_d;
  logic [ID_W-1:0]       cur_id, cur_id_d;
  logic [CNT_W-1:0]      cnt, cnt_d, cnt_inc;
  logic                  wr_done_q, done_rise;
  logic [NUM_REQ-1:0]    req_ready_d;
  logic                  wr_en_d, busy_d, cmp_valid_d;
  logic [DATA_WIDTH-1:0] num_row_d, sel_num_row;
  logic [ADDR_WIDTH-1:0] base_addr_d, sel_base_addr;
  logic [ID_W-1:0]       cmp_id_d;
  cmp_err_e              cmp_err_d;

  logic                  arb_en, arb_valid;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]       arb_id;

  // arbitrate only while no grant is outstanding
  assign arb_en = (state == IDLE) && (req_ready == '0);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (arb_grant),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  assign sel_num_row   = req_num_row[cur_id];
  assign sel_base_addr = req_base_addr[cur_id];
  assign done_rise     = wr_done & ~wr_done_q;
  assign cnt_inc       = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cur_id_d    = cur_id;
    cnt_d       = '0;
    req_ready_d = '0;
    wr_en_d     = 1'b0;
    num_row_d   = num_row;
    base_addr_d = base_addr;
    cmp_valid_d = 1'b0;
    cmp_id_d    = '0;
    cmp_err_d   = ERR_NONE;

    case (state)
      IDLE: begin
        num_row_d   = '0;
        base_addr_d = '0;
        if (req_ready == '0) begin
          if (arb_valid) begin
            req_ready_d = arb_grant;
            cur_id_d    = arb_id;
          end
        end else if ((req_ready & req_valid) != '0) begin
          ptr_d = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
          if (sel_num_row == '0) begin
            state_d     = DONE;
            cmp_valid_d = 1'b1;
            cmp_id_d    = cur_id;
            cmp_err_d   = ERR_NONE;
          end else if (sel_num_row > DATA_WIDTH'(MAX_ROW)) begin
            state_d     = DONE;
            cmp_valid_d = 1'b1;
            cmp_id_d    = cur_id;
            cmp_err_d   = ERR_LEN;
          end else begin
            state_d     = ISSUE;
            wr_en_d     = 1'b1;
            num_row_d   = sel_num_row;
            base_addr_d = sel_base_addr;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done_rise) begin
          state_d     = DONE;
          cmp_valid_d = 1'b1;
          cmp_id_d    = cur_id;
          cmp_err_d   = ERR_NONE;
          num_row_d   = '0;
          base_addr_d = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d     = DONE;
          cmp_valid_d = 1'b1;
          cmp_id_d    = cur_id;
          cmp_err_d   = ERR_TIMEOUT;
          num_row_d   = '0;
          base_addr_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_id    <= '0;
      cnt       <= '0;
      wr_done_q <= 1'b0;
      req_ready <= '0;
      wr_en_in  <= 1'b0;
      num_row   <= '0;
      base_addr <= '0;
      busy      <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_id    <= '0;
      cmp_err   <= 2'd0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cur_id    <= cur_id_d;
      cnt       <= cnt_d;
      wr_done_q <= wr_done;
      req_ready <= req_ready_d;
      wr_en_in  <= wr_en_d;
      num_row   <= num_row_d;
      base_addr <= base_addr_d;
      busy      <= busy_d;
      cmp_valid <= cmp_valid_d;
      cmp_id    <= cmp_id_d;
      cmp_err   <= cmp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_wr_sched.sv
// Scoreboard bench for mem_wr_sched: requester driver, write-controller
// model and a monitor that checks issue, hold and completion per command.
module tb_mem_wr_sched;

  localparam int NUM_REQ = 3;
  localparam int DW      = 16;
  localparam int AW      = 8;
  localparam int MAXR    = 256;
  localparam int TMO     = 16;
  localparam int IDW     = 2;

  logic                        clk;
  logic                        rstn;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0][DW-1:0]  req_num_row;
  logic [NUM_REQ-1:0][AW-1:0]  req_base_addr;
  logic                        wr_en_in;
  logic [DW-1:0]               num_row;
  logic [AW-1:0]               base_addr;
  logic                        wr_done;
  logic                        busy;
  logic                        cmp_valid;
  logic [IDW-1:0]              cmp_id;
  logic [1:0]                  cmp_err;

  mem_wr_sched #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .MAX_ROW(MAXR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num_row(req_num_row), .req_base_addr(req_base_addr),
    .wr_en_in(wr_en_in), .num_row(num_row), .base_addr(base_addr),
    .wr_done(wr_done), .busy(busy),
    .cmp_valid(cmp_valid), .cmp_id(cmp_id), .cmp_err(cmp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int err;
    bit issue;
    int nrow;
    int base;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   ctl_dly = 3;
  bit   ctl_hang = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // write controller: done level rises D+1 negedges after wr_en_in is seen,
  // dropping first if still high from the previous command
  int ctl_cnt = 0;
  bit ctl_act = 1'b0;
  initial begin
    wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        wr_done = 1'b0;
        ctl_act = 1'b0;
      end else if (wr_en_in) begin
        ctl_act = 1'b1;
        ctl_cnt = ctl_dly;
      end else if (ctl_act) begin
        if (ctl_cnt == 0) begin
          if (!ctl_hang) wr_done = 1'b1;
          ctl_act = 1'b0;
        end else begin
          if (ctl_cnt == 2) wr_done = 1'b0;
          ctl_cnt--;
        end
      end
    end
  end

  // monitor
  bit          in_flight = 1'b0;
  int          lat = 0;
  logic [DW-1:0] h_nrow;
  logic [AW-1:0] h_base;
  always @(negedge clk) begin
    if (!rstn) begin
      in_flight = 1'b0;
      exp_q.delete();
    end else begin
      if (in_flight) lat++;
      if (in_flight && !cmp_valid) begin
        check_val("hold_num_row", num_row, h_nrow);
        check_val("hold_base", base_addr, h_base);
        check_val("wr_en_single", wr_en_in, 0);
        check_val("busy_wait", busy, 1);
      end
      if (wr_en_in && !in_flight) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_wr_en", wr_en_in, 0);
        end else begin
          check_val("issue_allowed", exp_q[0].issue, 1);
          check_val("issue_num_row", num_row, exp_q[0].nrow);
          check_val("issue_base", base_addr, exp_q[0].base);
        end
        in_flight = 1'b1;
        lat = 0;
        h_nrow = num_row;
        h_base = base_addr;
      end
      if (cmp_valid) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_cmp", cmp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("cmp_id", cmp_id, e.id);
          check_val("cmp_err", cmp_err, e.err);
          check_val("cmp_issued", in_flight, e.issue);
          if (e.issue) check_val("cmp_latency", lat, e.lat);
          check_val("done_num_row", num_row, 0);
          check_val("busy_done", busy, 1);
        end
        in_flight = 1'b0;
      end
    end
  end

  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    if (req_ready != '0) check_val("ready_onehot", $onehot(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic raise(input int i, input int nrow, input int base);
    req_num_row[i]   = DW'(nrow);
    req_base_addr[i] = AW'(base);
    req_valid[i]     = 1'b1;
  endtask

  task automatic push_exp(input int i, input int nrow, input int base);
    exp_t e;
    e.id    = i;
    e.nrow  = nrow;
    e.base  = base;
    e.issue = (nrow != 0) && (nrow <= MAXR);
    e.err   = (nrow > MAXR) ? 1 : 0;
    if (e.issue && ctl_hang) e.err = 2;
    e.lat   = ctl_hang ? TMO + 1 : ctl_dly + 2;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || req_valid != '0) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_q", exp_q.size(), 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_num_row", num_row, 0);
  endtask

  task automatic single(input int i, input int nrow, input int base);
    raise(i, nrow, base);
    push_exp(i, nrow, base);
    drain(200);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, req_ready, 0);
    check_val({tag, "_wr_en"}, wr_en_in, 0);
    check_val({tag, "_num_row"}, num_row, 0);
    check_val({tag, "_base"}, base_addr, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_cmp_valid"}, cmp_valid, 0);
    check_val({tag, "_cmp_id"}, cmp_id, 0);
    check_val({tag, "_cmp_err"}, cmp_err, 0);
  endtask

  initial begin
    rstn          = 1'b0;
    req_valid     = '0;
    req_num_row   = '0;
    req_base_addr = '0;
    repeat (3) tick();
    check_all_zero("rst");
    rstn = 1'b1;
    tick();
    check_all_zero("post_rst");

    // contention twice: ptr wraps back to 0 after serving 2
    ctl_dly = 3;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_REQ; i++) raise(i, 2, 8'h20 + i + 4 * r);
      for (int i = 0; i < NUM_REQ; i++) push_exp(i, 2, 8'h20 + i + 4 * r);
      drain(300);
    end

    single(0, 4, 8'h10);
    single(1, 0, 8'h11);
    single(2, 300, 8'h12);
    single(0, MAXR, 8'h13);
    single(1, MAXR + 1, 8'h14);
    single(2, 1, 8'h15);

    ctl_hang = 1'b1;
    single(2, 5, 8'h33);
    ctl_hang = 1'b0;

    // done level left high by the first command straddles the second ISSUE
    ctl_dly = 4;
    single(0, 3, 8'h40);
    ctl_dly = 6;
    single(0, 7, 8'h41);

    // reset in the middle of WAIT, with ptr left pointing at requester 2
    ctl_hang = 1'b1;
    raise(1, 9, 8'h55);
    push_exp(1, 9, 8'h55);
    repeat (6) tick();
    check_val("pre_rst_busy", busy, 1);
    #1 rstn = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    tick();
    check_val("rst_hold_cmp", cmp_valid, 0);
    rstn = 1'b1;
    ctl_hang = 1'b0;
    ctl_dly = 3;
    tick();
    raise(2, 6, 8'h62);
    raise(1, 5, 8'h61);
    push_exp(1, 5, 8'h61);
    push_exp(2, 6, 8'h62);
    drain(300);

    for (int k = 0; k < 8; k++) begin
      int i, nrow, sel;
      i    = $urandom_range(0, NUM_REQ - 1);
      sel  = $urandom_range(0, 5);
      nrow = (sel == 0) ? 0 : (sel == 1) ? MAXR : (sel == 2) ? MAXR + 1 :
             $urandom_range(1, 40);
      ctl_dly = $urandom_range(3, 8);
      single(i, nrow, $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
